// File: rtl/view_pkg.sv
// Shared defaults, FSM encoding, coordinate field layout and camera clamp helper
// for the view_transform block.
package view_pkg;

  localparam int OBJ_N_DEF      = 20;
  localparam int SCREEN_W_DEF   = 640;
  localparam int CAM_ANCHOR_DEF = 320;
  localparam int LEVEL_W_DEF    = 3200;

  // Packed 32-bit coordinate/size word: X (or width) high, Y (or height) low.
  localparam int X_HI = 31;
  localparam int X_LO = 16;
  localparam int Y_HI = 15;
  localparam int Y_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CAM    = 2'd1,
    ST_SCAN   = 2'd2,
    ST_COMMIT = 2'd3
  } view_state_e;

  // Anchored camera target, clamped to [0, max_cam]; an underflow clamps to 0.
  function automatic logic [15:0] cam_target(input logic [15:0] px,
                                             input logic [15:0] anchor,
                                             input logic [15:0] max_cam);
    logic [15:0] diff;
    diff = '0;
    if (px < anchor) return '0;
    diff = px - anchor;
    return (diff > max_cam) ? max_cam : diff;
  endfunction

endpackage

// File: rtl/view_transform_cull.sv
// view_cull: combinational world-to-screen offset and visibility test for one
// object against the current camera.
module view_cull
  import view_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF
) (
  input  logic [31:0] obj_coord,
  input  logic [31:0] obj_size,
  input  logic [15:0] cam_x,
  output logic [31:0] scr_coord,
  output logic        visible
);

  logic [15:0] obj_x;
  logic [15:0] obj_y;
  logic [15:0] obj_w;
  logic [16:0] right_edge;
  logic [16:0] view_right;
  logic        unused_height;

  assign obj_x         = obj_coord[X_HI:X_LO];
  assign obj_y         = obj_coord[Y_HI:Y_LO];
  assign obj_w         = obj_size[X_HI:X_LO];
  assign unused_height = ^obj_size[Y_HI:Y_LO];

  // 17-bit sums so edges past 65535 compare correctly instead of wrapping.
  assign right_edge = {1'b0, obj_x} + {1'b0, obj_w};
  assign view_right = {1'b0, cam_x} + 17'(SCREEN_W);

  assign scr_coord = {obj_x - cam_x, obj_y};
  assign visible   = (obj_w != '0) && (right_edge > {1'b0, cam_x}) &&
                     ({1'b0, obj_x} < view_right);

endmodule

// File: rtl/view_transform.sv
// view_transform: per-frame camera update and object culling into a shadow
// buffer, committed atomically. Define VIEW_CAM_BACKSCROLL_EN for a two-way camera.
module view_transform
  import view_pkg::*;
#(
  parameter int OBJ_N      = OBJ_N_DEF,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int CAM_ANCHOR = CAM_ANCHOR_DEF,
  parameter int LEVEL_W    = LEVEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          player_x,
  input  logic [32*OBJ_N-1:0]  obj_coord_array,
  input  logic [32*OBJ_N-1:0]  obj_size_array,
  output logic [32*OBJ_N-1:0]  vis_coord_array,
  output logic [OBJ_N-1:0]     vis_mask,
  output logic [15:0]          cam_x,
  output logic                 busy,
  output logic                 done
);

  localparam int               IDX_W    = (OBJ_N > 1) ? $clog2(OBJ_N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OBJ_N - 1);
  localparam logic [15:0]      ANCHOR   = 16'(CAM_ANCHOR);
  localparam logic [15:0]      MAX_CAM  = 16'(LEVEL_W - SCREEN_W);

  view_state_e state_q, state_d;

  logic [IDX_W-1:0]     idx_q;
  logic [15:0]          snap_px;
  logic [32*OBJ_N-1:0]  snap_coord;
  logic [32*OBJ_N-1:0]  snap_size;
  logic [32*OBJ_N-1:0]  shadow_coord;
  logic [OBJ_N-1:0]     shadow_mask;
  logic [31:0]          cur_coord;
  logic [31:0]          cur_size;
  logic [31:0]          cur_scr;
  logic                 cur_vis;
  logic [15:0]          target;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_CAM;
      ST_CAM:    state_d = ST_SCAN;
      ST_SCAN:   if (idx_q == LAST_IDX) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  assign cur_coord = snap_coord[idx_q*32 +: 32];
  assign cur_size  = snap_size[idx_q*32 +: 32];
  assign target    = cam_target(snap_px, ANCHOR, MAX_CAM);

  view_cull #(
    .SCREEN_W (SCREEN_W)
  ) u_cull (
    .obj_coord (cur_coord),
    .obj_size  (cur_size),
    .cam_x     (cam_x),
    .scr_coord (cur_scr),
    .visible   (cur_vis)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q           <= '0;
      snap_px         <= '0;
      snap_coord      <= '0;
      snap_size       <= '0;
      shadow_coord    <= '0;
      shadow_mask     <= '0;
      vis_coord_array <= '0;
      vis_mask        <= '0;
      cam_x           <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_px    <= player_x;
            snap_coord <= obj_coord_array;
            snap_size  <= obj_size_array;
          end
        end
        ST_CAM: begin
`ifdef VIEW_CAM_BACKSCROLL_EN
          cam_x <= target;
`else
          cam_x <= (target > cam_x) ? target : cam_x;
`endif
          idx_q <= '0;
        end
        ST_SCAN: begin
          shadow_coord[idx_q*32 +: 32] <= cur_scr;
          shadow_mask[idx_q]           <= cur_vis;
          idx_q                        <= idx_q + 1'b1;
        end
        ST_COMMIT: begin
          vis_coord_array <= shadow_coord;
          vis_mask        <= shadow_mask;
          done            <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
